// File: rtl/doc_safety_cc_scheduler_pkg.sv
// Shared types for the safety cross-comparison scheduler: payload layout,
// FSM state encoding, fault codes and the payload match rule.
package pkg_doc_safety;

  localparam int SPEED_W = 16;

  typedef logic [SPEED_W-1:0] t_speed;

  typedef struct packed {
    t_speed     speed_rpm;
    logic       over_speed;
    logic [7:0] seq_cnt;
  } t_safety_payload;

  typedef enum logic [2:0] {
    CC_IDLE      = 3'd0,
    CC_GEN       = 3'd1,
    CC_LATCH     = 3'd2,
    CC_SEND      = 3'd3,
    CC_WAIT_PEER = 3'd4,
    CC_COMPARE   = 3'd5,
    CC_FAULT     = 3'd6
  } t_cc_state;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_MISMATCH = 2'd2;
  localparam logic [1:0] FC_OVERRUN  = 2'd3;

  // One extra bit keeps the speed difference exact for any pair of speeds.
  function automatic logic cc_match(input t_safety_payload loc,
                                    input t_safety_payload peer,
                                    input t_speed          margin);
    logic signed [SPEED_W:0] diff;
    logic        [SPEED_W:0] mag;
    diff = $signed({1'b0, loc.speed_rpm}) - $signed({1'b0, peer.speed_rpm});
    mag  = diff[SPEED_W] ? $unsigned(-diff) : $unsigned(diff);
    return (loc.seq_cnt == peer.seq_cnt) &&
           (loc.over_speed == peer.over_speed) &&
           (mag <= {1'b0, margin});
  endfunction

endpackage

// File: rtl/doc_safety_period_timer.sv
// Free-running period timer: counts 0..P_TERMINAL, pulses tick on the
// terminal count, and parks at 0 while disabled.
module doc_safety_period_timer #(
  parameter int P_TERMINAL = 99_999
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int W = (P_TERMINAL > 0) ? $clog2(P_TERMINAL + 1) : 1;
  localparam logic [W-1:0] TC = W'(P_TERMINAL);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = enable && (cnt == TC);

endmodule

// File: rtl/doc_safety_cc_scheduler.sv
// Periodic cross-comparison of the local safety payload against the peer
// channel, with timeout, mismatch-limit and period-overrun fault detection.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for the period tick
// GEN       | generate_payload pulse to the payload generator
// LATCH     | capture generator output into tx_payload
// SEND      | tx_valid held until the peer link accepts
// WAIT_PEER | waiting for a buffered peer payload, timeout running
// COMPARE   | evaluate match, pulse pass/mismatch
// FAULT     | absorbing until reset
module doc_safety_cc_scheduler
  import pkg_doc_safety::*;
#(
  parameter int P_PERIOD_CYCLES       = 100_000,
  parameter int P_RESP_TIMEOUT_CYCLES = 10_000,
  parameter int P_MAX_MISMATCH        = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            generate_payload,
  input  t_safety_payload local_payload,
  input  t_speed          speed_cc_margin,
  output t_safety_payload tx_payload,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  t_safety_payload peer_payload,
  input  logic            peer_valid,
  output logic            cc_pass,
  output logic            cc_mismatch,
  output logic            cc_fault,
  output logic [1:0]      fault_code,
  output logic [7:0]      mismatch_cnt
);

  localparam logic [2:0] S_IDLE      = CC_IDLE;
  localparam logic [2:0] S_GEN       = CC_GEN;
  localparam logic [2:0] S_LATCH     = CC_LATCH;
  localparam logic [2:0] S_SEND      = CC_SEND;
  localparam logic [2:0] S_WAIT_PEER = CC_WAIT_PEER;
  localparam logic [2:0] S_COMPARE   = CC_COMPARE;
  localparam logic [2:0] S_FAULT     = CC_FAULT;

  localparam int TW = (P_RESP_TIMEOUT_CYCLES > 1) ? $clog2(P_RESP_TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(P_RESP_TIMEOUT_CYCLES - 1);

  logic [2:0]      state, state_nxt;
  logic [1:0]      fc_nxt;
  logic            tick;
  logic            overrun;
  logic [TW-1:0]   to_cnt;
  logic            buf_full;
  t_safety_payload buf_data;
  t_safety_payload cmp_peer;
  logic            peer_avail;
  logic            match;
  logic [7:0]      mm_inc;
  logic            mm_limit;

  doc_safety_period_timer #(
    .P_TERMINAL (P_PERIOD_CYCLES - 1)
  ) u_period_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // A strobe arriving this cycle counts as buffered, so a peer payload on the
  // last timeout cycle still wins over the timeout.
  assign peer_avail = buf_full || peer_valid;
  assign overrun    = tick && (state != S_IDLE) && (state != S_FAULT);
  assign match      = cc_match(tx_payload, cmp_peer, speed_cc_margin);
  assign mm_inc     = (mismatch_cnt == 8'hFF) ? 8'hFF : mismatch_cnt + 8'd1;
  assign mm_limit   = 32'(mm_inc) >= P_MAX_MISMATCH;

  always_comb begin
    state_nxt = state;
    fc_nxt    = FC_NONE;
    case (state)
      S_IDLE:      if (tick) state_nxt = S_GEN;
      S_GEN:       state_nxt = S_LATCH;
      S_LATCH:     state_nxt = S_SEND;
      S_SEND:      if (tx_ready) state_nxt = S_WAIT_PEER;
      S_WAIT_PEER: begin
        if (peer_avail) begin
          state_nxt = S_COMPARE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_TIMEOUT;
        end
      end
      S_COMPARE: begin
        if (!match && mm_limit) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_MISMATCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FAULT:     state_nxt = S_FAULT;
      default:     state_nxt = S_IDLE;
    endcase
    if (overrun) begin
      state_nxt = S_FAULT;
      fc_nxt    = FC_OVERRUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      cmp_peer     <= '0;
      tx_payload   <= '0;
      cc_pass      <= 1'b0;
      cc_mismatch  <= 1'b0;
      fault_code   <= FC_NONE;
      mismatch_cnt <= '0;
    end else begin
      state       <= state_nxt;
      cc_pass     <= 1'b0;
      cc_mismatch <= 1'b0;

      if (state == S_LATCH) tx_payload <= local_payload;

      if (state == S_SEND) begin
        to_cnt <= '0;
      end else if (state == S_WAIT_PEER) begin
        to_cnt <= to_cnt + TW'(1);
      end

      // Consuming entry takes a same-cycle strobe directly; otherwise newest wins.
      if (state != S_FAULT) begin
        if (state_nxt == S_COMPARE) begin
          cmp_peer <= peer_valid ? peer_payload : buf_data;
          buf_full <= 1'b0;
        end else if (peer_valid) begin
          buf_data <= peer_payload;
          buf_full <= 1'b1;
        end
      end

      if (state == S_COMPARE && !overrun) begin
        if (match) begin
          cc_pass      <= 1'b1;
          mismatch_cnt <= '0;
        end else begin
          cc_mismatch  <= 1'b1;
          mismatch_cnt <= mm_inc;
        end
      end

      if (state != S_FAULT && state_nxt == S_FAULT) fault_code <= fc_nxt;
    end
  end

  assign generate_payload = (state == S_GEN);
  assign tx_valid         = (state == S_SEND);
  assign cc_fault         = (state == S_FAULT);

endmodule

// File: tb/tb_doc_safety_cc_scheduler.sv
// Directed bench for the cross-comparison scheduler with a simple peer
// responder and a cycle-stamped event monitor.
module tb_doc_safety_cc_scheduler;
  import pkg_doc_safety::*;

  logic            clk;
  logic            reset;
  logic            enable;
  logic            generate_payload;
  t_safety_payload local_payload;
  t_speed          speed_cc_margin;
  t_safety_payload tx_payload;
  logic            tx_valid;
  logic            tx_ready;
  t_safety_payload peer_payload;
  logic            peer_valid;
  logic            cc_pass;
  logic            cc_mismatch;
  logic            cc_fault;
  logic [1:0]      fault_code;
  logic [7:0]      mismatch_cnt;

  int n_vec;
  int n_bad;
  int cyc, n_gen, n_pass, n_mis, n_acc;
  int last_gen, prev_gen, last_pass, last_mis, last_acc, fault_cyc;
  bit fault_seen;
  int peer_mode, peer_delay;
  bit sent;

  doc_safety_cc_scheduler #(
    .P_PERIOD_CYCLES       (20),
    .P_RESP_TIMEOUT_CYCLES (8),
    .P_MAX_MISMATCH        (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .generate_payload (generate_payload),
    .local_payload    (local_payload),
    .speed_cc_margin  (speed_cc_margin),
    .tx_payload       (tx_payload),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .peer_payload     (peer_payload),
    .peer_valid       (peer_valid),
    .cc_pass          (cc_pass),
    .cc_mismatch      (cc_mismatch),
    .cc_fault         (cc_fault),
    .fault_code       (fault_code),
    .mismatch_cnt     (mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the falling edge.
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic t_safety_payload mk(input int spd, input bit ov, input int seq);
    t_safety_payload p;
    p.speed_rpm  = t_speed'(spd);
    p.over_speed = ov;
    p.seq_cnt    = 8'(seq);
    return p;
  endfunction

  // Monitor samples 1 ns before each rising edge; cyc numbers the cycle sampled.
  initial begin
    cyc = 0; n_gen = 0; n_pass = 0; n_mis = 0; n_acc = 0;
    last_gen = 0; prev_gen = 0; last_pass = 0; last_mis = 0; last_acc = 0;
    fault_cyc = 0; fault_seen = 0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (generate_payload) begin prev_gen = last_gen; last_gen = cyc; n_gen++; end
      if (cc_pass) begin last_pass = cyc; n_pass++; end
      if (cc_mismatch) begin last_mis = cyc; n_mis++; end
      if (tx_valid && tx_ready) begin last_acc = cyc; n_acc++; end
      if (cc_fault && !fault_seen) begin fault_seen = 1; fault_cyc = cyc; end
    end
  end

  // Peer: mode 1 answers peer_delay cycles after accept, mode 2 answers during SEND.
  initial begin
    peer_valid = 1'b0;
    sent = 0;
    forever begin
      tick_n(1);
      if (peer_mode == 1 && tx_valid && tx_ready) begin
        tick_n(peer_delay);
        peer_valid = 1'b1;
        tick_n(1);
        peer_valid = 1'b0;
      end else if (peer_mode == 2 && tx_valid && !sent) begin
        sent = 1;
        peer_valid = 1'b1;
        tick_n(1);
        peer_valid = 1'b0;
      end
      if (!tx_valid) sent = 0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_gen"},   32'(generate_payload), 32'd0);
    chk({tag, "_txv"},   32'(tx_valid),         32'd0);
    chk({tag, "_pass"},  32'(cc_pass),          32'd0);
    chk({tag, "_mis"},   32'(cc_mismatch),      32'd0);
    chk({tag, "_fault"}, 32'(cc_fault),         32'd0);
    chk({tag, "_code"},  32'(fault_code),       32'd0);
    chk({tag, "_cnt"},   32'(mismatch_cnt),     32'd0);
    chk({tag, "_txp"},   32'(tx_payload),       32'd0);
  endtask

  // Timer sits at 0 in the release cycle, so the first GEN is mark+20.
  task automatic do_reset(input string tag, output int mark);
    reset = 1'b1;
    tick_n(2);
    check_zero(tag);
    reset = 1'b0;
    mark = cyc + 1;
    fault_seen = 0;
  endtask

  task automatic wait_result(output int kind);
    int p0, m0;
    p0 = n_pass;
    m0 = n_mis;
    kind = 0;
    for (int i = 0; i < 80 && kind == 0; i++) begin
      tick_n(1);
      if (n_pass != p0) kind = 1;
      else if (n_mis != m0) kind = 2;
    end
  endtask

  task automatic wait_gen(input string tag);
    int g0;
    bit ok;
    g0 = n_gen;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick_n(1);
      if (n_gen != g0) ok = 1;
    end
    chk({tag, "_gen_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_fault(input string tag);
    for (int i = 0; i < 80 && !fault_seen; i++) tick_n(1);
    tick_n(1);
    chk({tag, "_fault_seen"}, 32'(fault_seen), 32'd1);
  endtask

  task automatic wait_acc(input string tag);
    int a0;
    bit ok;
    a0 = n_acc;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick_n(1);
      if (n_acc != a0) ok = 1;
    end
    chk({tag, "_acc_seen"}, 32'(ok), 32'd1);
  endtask

  int m_spd  [7] = '{1130, 870, 869, 1000, 1131, 1000, 1000};
  bit m_ov   [7] = '{0, 0, 0, 0, 0, 1, 0};
  int m_kind [7] = '{1, 1, 2, 1, 2, 2, 1};
  int m_cnt  [7] = '{0, 0, 1, 0, 1, 2, 0};

  initial begin
    int mark, k, g0, m0;
    n_vec = 0;
    n_bad = 0;
    peer_mode = 0;
    peer_delay = 0;
    reset = 1'b1;
    enable = 1'b0;
    tx_ready = 1'b0;
    speed_cc_margin = 16'd130;
    local_payload = mk(1000, 0, 5);
    peer_payload  = mk(1100, 0, 5);
    tick_n(1);

    // nominal
    tx_ready = 1'b1; peer_mode = 1; peer_delay = 2; enable = 1'b1;
    do_reset("rst0", mark);
    wait_result(k);
    chk("nom_kind0", k, 1);
    chk("nom_first_gen", last_gen - mark, 20);
    chk("nom_pass_lat", last_pass - last_gen, 6);
    for (int i = 0; i < 2; i++) begin
      wait_result(k);
      chk($sformatf("nom_kind%0d", i + 1), k, 1);
    end
    chk("nom_period", last_gen - prev_gen, 20);
    chk("nom_cnt", 32'(mismatch_cnt), 32'd0);
    chk("nom_nmis", n_mis, 0);

    // margin boundary, both signs of the difference
    for (int i = 0; i < 7; i++) begin
      peer_payload = mk(m_spd[i], m_ov[i], 5);
      wait_result(k);
      chk($sformatf("margin%0d_kind", i), k, m_kind[i]);
      chk($sformatf("margin%0d_cnt", i), 32'(mismatch_cnt), m_cnt[i]);
    end

    // mismatch limit
    peer_payload = mk(1000, 0, 6);
    fault_seen = 0;
    for (int i = 1; i <= 3; i++) begin
      wait_result(k);
      chk($sformatf("mm%0d_kind", i), k, 2);
      chk($sformatf("mm%0d_cnt", i), 32'(mismatch_cnt), i);
    end
    tick_n(2);
    chk("mm_fault_seen", 32'(fault_seen), 32'd1);
    chk("mm_fault", 32'(cc_fault), 32'd1);
    chk("mm_code", 32'(fault_code), 32'd2);
    chk("mm_fault_cyc", fault_cyc - last_mis, 0);
    g0 = n_gen;
    tick_n(60);
    chk("mm_no_gen", n_gen - g0, 0);
    chk("mm_txv", 32'(tx_valid), 32'd0);
    chk("mm_code_held", 32'(fault_code), 32'd2);

    // timeout with no peer answer
    peer_mode = 0;
    peer_payload = mk(1000, 0, 5);
    do_reset("rst_to", mark);
    wait_fault("to");
    chk("to_code", 32'(fault_code), 32'd1);
    chk("to_lat", fault_cyc - last_acc, 9);

    // peer answer on the last timeout cycle
    peer_mode = 1; peer_delay = 8;
    do_reset("rst_late", mark);
    wait_result(k);
    chk("late_kind", k, 1);
    chk("late_lat", last_pass - last_acc, 10);
    chk("late_fault", 32'(cc_fault), 32'd0);

    // period overrun
    peer_mode = 0;
    tx_ready = 1'b0;
    do_reset("rst_ov", mark);
    wait_fault("ov");
    chk("ov_code", 32'(fault_code), 32'd3);
    chk("ov_lat", fault_cyc - last_gen, 20);
    chk("ov_txv", 32'(tx_valid), 32'd0);

    // peer payload arrives while still in SEND
    peer_mode = 2;
    do_reset("rst_snd", mark);
    wait_gen("snd");
    tick_n(5);
    tx_ready = 1'b1;
    wait_result(k);
    chk("snd_kind", k, 1);
    chk("snd_lat", last_pass - last_acc, 3);
    chk("snd_fault", 32'(cc_fault), 32'd0);

    // reset while waiting for the peer, then resume
    peer_mode = 0;
    do_reset("rst_w0", mark);
    wait_acc("rw");
    tick_n(1);
    reset = 1'b1;
    tick_n(1);
    check_zero("rst_wait");
    m0 = n_mis;
    reset = 1'b0;
    peer_mode = 1; peer_delay = 2;
    wait_result(k);
    chk("rw_resume_kind", k, 1);
    chk("rw_resume_nmis", n_mis - m0, 0);

    // enable dropped mid-transaction
    wait_gen("en");
    enable = 1'b0;
    wait_result(k);
    chk("en_finish_kind", k, 1);
    g0 = n_gen;
    tick_n(50);
    chk("en_idle_gen", n_gen - g0, 0);
    chk("en_idle_txv", 32'(tx_valid), 32'd0);
    enable = 1'b1;
    mark = cyc + 1;
    wait_gen("en_re");
    chk("en_restart", last_gen - mark, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/doc_safety_cc_scheduler.md
DOC_SAFETY_CC_SCHEDULER -- requirements
Module: doc_safety_cc_scheduler

Interface
REQ-001 SHALL have parameter P_PERIOD_CYCLES, default 100_000: cross-comparison period in clk cycles (1 ms at 100 MHz).
REQ-002 SHALL have parameter P_RESP_TIMEOUT_CYCLES, default 10_000: maximum wait for the peer payload, counted from local send acceptance.
REQ-003 SHALL have parameter P_MAX_MISMATCH, default 3: number of consecutive mismatches that trips a fault.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: scheduling enable.
REQ-008 SHALL have port generate_payload, output, 1: one-cycle pulse to the payload generator and FuSa heartbeat.
REQ-009 SHALL have port local_payload, input, t_safety_payload: registered generator output, valid 1 cycle after generate_payload.
REQ-010 SHALL have port speed_cc_margin, input, t_speed: allowed speed difference in RPM.
REQ-011 SHALL have ports tx_payload (output, t_safety_payload), tx_valid (output, 1) and tx_ready (input, 1): valid/ready send of the local payload to the peer.
REQ-012 SHALL have ports peer_payload (input, t_safety_payload) and peer_valid (input, 1): single-cycle strobe carrying the peer payload.
REQ-013 SHALL have port cc_pass, output, 1: one-cycle pulse on a matching comparison.
REQ-014 SHALL have port cc_mismatch, output, 1: one-cycle pulse on a non-matching comparison.
REQ-015 SHALL have port cc_fault, output, 1: sticky fault flag.
REQ-016 SHALL have port fault_code, output, 2: 0 none, 1 timeout, 2 mismatch limit, 3 period overrun.
REQ-017 SHALL have port mismatch_cnt, output, 8: current count of consecutive mismatches.

Function
REQ-018 The period timer SHALL count 0..P_PERIOD_CYCLES-1, wrap, and emit tick at the terminal count while enable=1, and SHALL be held at 0 while enable=0.
REQ-019 The FSM SHALL have states IDLE, GEN, LATCH, SEND, WAIT_PEER, COMPARE and FAULT.
REQ-020 IDLE->GEN SHALL occur on tick; GEN SHALL drive generate_payload=1 for exactly one cycle.
REQ-021 In GEN->LATCH, LATCH SHALL capture local_payload into tx_payload and then go to SEND.
REQ-022 In SEND, tx_valid=1 and tx_payload SHALL hold stable until tx_ready; the accept cycle SHALL go to WAIT_PEER and clear the timeout counter.
REQ-023 A one-entry peer buffer SHALL capture peer_payload on any peer_valid in any non-FAULT state, the newest capture overwriting an unconsumed one, and SHALL be consumed on entry to COMPARE.
REQ-024 WAIT_PEER SHALL go to COMPARE when the buffer is full, including a capture made during SEND, and otherwise SHALL go to FAULT with code 1 when the timeout counter reaches P_RESP_TIMEOUT_CYCLES-1.
REQ-025 Match in COMPARE SHALL be: seq_cnt equal AND over_speed equal AND |local.speed_rpm - peer.speed_rpm| <= speed_cc_margin.
REQ-026 The speed difference SHALL be computed at t_speed width +1, signed, so that it cannot overflow.
REQ-027 On match, COMPARE SHALL pulse cc_pass, clear mismatch_cnt and go to IDLE.
REQ-028 On mismatch, COMPARE SHALL pulse cc_mismatch and increment mismatch_cnt, saturating at 255.
REQ-029 After a mismatch, COMPARE SHALL go to FAULT with code 2 if the new count >= P_MAX_MISMATCH, and otherwise to IDLE.
REQ-030 A tick in any state other than IDLE and FAULT SHALL go to FAULT with code 3, taking priority over that cycle's other transitions.
REQ-031 FAULT SHALL be absorbing until reset: cc_fault=1, fault_code held, tx_valid=0, generate_payload=0.
REQ-032 On simultaneous timeout and buffer-full in WAIT_PEER, COMPARE SHALL win.
REQ-033 enable deasserted mid-transaction SHALL let the FSM complete the current transaction and then rest in IDLE.
REQ-034 cc_fault SHALL assert in the cycle after the FAULT transition is decided.

Reset
REQ-035 On reset=1 at a clk edge, the block SHALL set state IDLE, timers 0, peer buffer empty, and tx_payload to all zeros.
REQ-036 On reset=1 at a clk edge, the block SHALL set all outputs to 0, including generate_payload, tx_valid, cc_pass, cc_mismatch, cc_fault, fault_code and mismatch_cnt.
REQ-037 A reset asserted mid-transaction SHALL abort the transaction with no pulse emitted.

Structure
REQ-038 t_safety_payload (fields speed_rpm : t_speed, over_speed : 1 bit, seq_cnt : 8 bits), t_speed and a t_cc_state enum SHALL live in pkg_doc_safety.
REQ-039 Fault code constants SHALL also live in pkg_doc_safety.
REQ-040 The period timer SHALL be a sub-module doc_safety_period_timer (enable, tick, terminal-count parameter); all else SHALL be flat.

Verification
Parameters for all scenarios: P_PERIOD_CYCLES=20, P_RESP_TIMEOUT_CYCLES=8, P_MAX_MISMATCH=3, margin=130.
REQ-041 Nominal: local speed 1000, peer speed 1100, seq 5/5, tx_ready immediate -> generate_payload every 20 cycles, cc_pass each period, mismatch_cnt=0.
REQ-042 Margin boundary: diff=130 -> cc_pass; diff=131 -> cc_mismatch with mismatch_cnt=1; then a match -> mismatch_cnt=0.
REQ-043 Mismatch limit: seq 5 vs 6 for three periods -> cc_mismatch x3, then cc_fault=1 and fault_code=2, with no further generate_payload.
REQ-044 Timeout: no peer_valid -> FAULT with code 1 exactly 8 cycles after tx accept; peer_valid arriving on the final timeout cycle -> cc_pass instead.
REQ-045 Overrun: tx_ready held low for 25 cycles -> fault_code=3 on the next tick.
REQ-046 Edge cases: peer_valid during SEND -> compared without timeout; reset asserted in WAIT_PEER -> all outputs 0 next cycle and normal operation resumes.
